// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with one outstanding request, output buffer and redirect squash
// Optional perf counters are built when FETCH_CTRL_PERF_EN is defined; otherwise both ports read 0.
module fetch_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [DATA_WIDTH-1:0]    redirect_target,
    input  logic                     dec_ready,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_squashed
);
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
    state_t state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] pc, pend_pc;
    logic fire, land;
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[DATA_WIDTH-1:ADDRESS_WIDTH];
    assign imem_addr = pc;
    assign fire = imem_req && imem_gnt;
    assign land = state == WAIT && imem_rvalid && !redirect;
    // Request only when the output register can take the result; a grant together with a redirect is squashed via DRAIN
    always_comb begin
        imem_req  = !rst && state == FETCH && (!if_valid || dec_ready);
        state_nxt = state;
        case (state)
            FETCH:   state_nxt = fire ? (redirect ? DRAIN : WAIT) : FETCH;
            WAIT:    state_nxt = imem_rvalid ? FETCH : (redirect ? DRAIN : WAIT);
            DRAIN:   state_nxt = imem_rvalid ? FETCH : DRAIN;
            default: state_nxt = FETCH;
        endcase
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end
    // PC, pending PC and the decode-facing output register; redirect overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= ADDRESS_WIDTH'(RESET_PC);
            pend_pc  <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            pc       <= redirect ? redirect_target[ADDRESS_WIDTH-1:0] : fire ? pc + ADDRESS_WIDTH'(4) : pc;
            pend_pc  <= fire ? pc : pend_pc;
            if_valid <= redirect ? 1'b0 : land ? 1'b1 : dec_ready ? 1'b0 : if_valid;
            if_instr <= land ? imem_rdata : if_instr;
            if_pc    <= land ? pend_pc : if_pc;
        end
    end
`ifdef FETCH_CTRL_PERF_EN
    logic drop;
    assign drop = imem_rvalid && (state == DRAIN || (state == WAIT && redirect));
    // Delivered and discarded instruction counters, free-running and wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            perf_fetched  <= perf_fetched + 32'(if_valid && dec_ready);
            perf_squashed <= perf_squashed + 32'(drop);
        end
    end
`else
    assign perf_fetched  = '0;
    assign perf_squashed = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard and vector-table bench for fetch_ctrl with a latency-configurable memory model
module tb_fetch_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk, rst, redirect, dec_ready, imem_req, imem_gnt, imem_rvalid, if_valid;
    logic [DW-1:0] redirect_target, imem_rdata, if_instr;
    logic [AW-1:0] imem_addr, if_pc;
    logic [31:0] perf_fetched, perf_squashed;

    fetch_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
        .dec_ready(dec_ready), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [AW-1:0] pc; logic [DW-1:0] instr;} exp_t;
    typedef struct {logic [31:0] tgt; logic [AW-1:0] a0; logic [AW-1:0] a1;} vec_t;
    exp_t sb[$];
    vec_t vt[5];
    int n_cmp = 0, n_bad = 0, acc_cnt = 0, sq_exp = 0, lat = 1, cnt = 0;
    logic armed = 1'b0, last_fire;
    logic [AW-1:0] last_addr, resp_addr;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return 32'h00100093 + ({27'd0, a} << 20);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        #1;
        if (if_valid && dec_ready) begin
            acc_cnt++;
            if (sb.size() == 0) chk("sb_unexpected_delivery", 32'(if_pc), 32'hffffffff);
            else begin
                e = sb.pop_front();
                chk("sb_if_pc", 32'(if_pc), 32'(e.pc));
                chk("sb_if_instr", if_instr, e.instr);
            end
        end
        if (redirect) sb.delete();
        last_fire = imem_req && imem_gnt;
        last_addr = imem_addr;
        if (last_fire) begin
            armed = 1'b1;
            cnt = lat;
            resp_addr = imem_addr;
            if (!redirect) begin
                e.pc = imem_addr;
                e.instr = mem_data(imem_addr);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (cnt > 0) cnt--;
        imem_rvalid = armed && cnt == 0;
        imem_rdata = imem_rvalid ? mem_data(resp_addr) : '0;
        if (imem_rvalid) armed = 1'b0;
    endtask

    task automatic wait_fire(input string nm, input logic [AW-1:0] ea, input int en);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!last_fire && n < 20);
        chk({nm, "_fire"}, 32'(last_fire), 32'd1);
        chk({nm, "_addr"}, 32'(last_addr), 32'(ea));
        if (en > 0) chk({nm, "_cycles"}, n, en);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        dec_ready = 1'b1;
        imem_gnt = 1'b1;
        armed = 1'b0;
        cnt = 0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        sb.delete();
        acc_cnt = 0;
        sq_exp = 0;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", 32'(if_pc), 0);
        chk("rst_perf_f", perf_fetched, 0);
        chk("rst_perf_s", perf_squashed, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_perf(input string nm);
        chk({nm, "_perf_fetched"}, perf_fetched, PERF ? 32'(acc_cnt) : 32'd0);
        chk({nm, "_perf_squashed"}, perf_squashed, PERF ? 32'(sq_exp) : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h0000001c, 5'd28, 5'd0};
        vt[1] = '{32'h00000010, 5'd16, 5'd20};
        vt[2] = '{32'hffffffe8, 5'd8,  5'd12};
        vt[3] = '{32'h0000003f, 5'd31, 5'd3};
        vt[4] = '{32'h00000004, 5'd4,  5'd8};
        rst = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        dec_ready = 1'b1;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        @(negedge clk);
        // streaming fetch, one instruction per two cycles
        do_reset();
        lat = 1;
        wait_fire("t1_0", 0, 1);
        wait_fire("t1_4", 4, 2);
        wait_fire("t1_8", 8, 2);
        wait_fire("t1_12", 12, 2);
        chk_perf("t1");
        // decode stall holds the output register and blocks requests
        do_reset();
        wait_fire("t2_0", 0, 1);
        wait_fire("t2_4", 4, 2);
        cyc();
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_hold_valid", 32'(if_valid), 1);
            chk("t2_hold_instr", if_instr, 32'h00500093);
            chk("t2_hold_pc", 32'(if_pc), 4);
            chk("t2_hold_req", 32'(imem_req), 0);
            cyc();
        end
        dec_ready = 1'b1;
        wait_fire("t2_8", 8, 1);
        chk_perf("t2");
        // redirect while waiting on a slow response drains it
        do_reset();
        lat = 2;
        wait_fire("t3_0", 0, 1);
        wait_fire("t3_4", 4, 3);
        wait_fire("t3_8", 8, 3);
        redirect = 1'b1;
        redirect_target = 32'h10;
        cyc();
        redirect = 1'b0;
        chk("t3_valid_cleared", 32'(if_valid), 0);
        sq_exp = 1;
        wait_fire("t3_16", 16, 2);
        chk_perf("t3");
        wait_fire("t3_20", 20, 3);
        // redirect coinciding with a grant squashes that request
        do_reset();
        lat = 1;
        redirect = 1'b1;
        redirect_target = 32'h0c;
        cyc();
        redirect = 1'b0;
        sq_exp = 1;
        wait_fire("t4_12", 12, 2);
        chk_perf("t4");
        wait_fire("t4_16", 16, 2);
        // vector table: redirect without grant, then two fetches including wraparound
        foreach (vt[k]) begin
            do_reset();
            imem_gnt = 1'b0;
            redirect = 1'b1;
            redirect_target = vt[k].tgt;
            cyc();
            redirect = 1'b0;
            imem_gnt = 1'b1;
            wait_fire($sformatf("tv%0d_a0", k), vt[k].a0, 1);
            wait_fire($sformatf("tv%0d_a1", k), vt[k].a1, 2);
        end
        // reset in the middle of a wait, then a stale response
        do_reset();
        lat = 2;
        wait_fire("t6_0", 0, 1);
        do_reset();
        imem_gnt = 1'b0;
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hdeadbeef;
        cyc();
        #1;
        chk("t6_valid", 32'(if_valid), 0);
        chk("t6_addr", 32'(imem_addr), 0);
        chk("t6_req", 32'(imem_req), 1);
        chk("t6_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the instruction-fetch stage. Owns the program counter and the next-PC selection, holds at most one outstanding instruction-memory request, and buffers the returned instruction in a single output register until decode accepts it. It also squashes in-flight fetches when execute redirects the PC on a taken branch or jump.

## Interface
Parameters:
- ADDRESS_WIDTH, 5: PC and instruction-memory address width.
- DATA_WIDTH, 32: instruction and immediate/target width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-high reset.
- redirect  input  1: taken branch or jump from execute (PCSrc).
- redirect_target  input  DATA_WIDTH: new PC. Only the low ADDRESS_WIDTH bits are used.
- dec_ready  input  1: decode accepts if_instr this cycle.
- imem_req  output  1: fetch request valid.
- imem_addr  output  ADDRESS_WIDTH: fetch address (current PC).
- imem_gnt  input  1: memory accepts the request this cycle.
- imem_rvalid  input  1: response data valid.
- imem_rdata  input  DATA_WIDTH: response instruction.
- if_valid  output  1: if_instr/if_pc are valid.
- if_instr  output  DATA_WIDTH: fetched instruction.
- if_pc  output  ADDRESS_WIDTH: address of if_instr.
- perf_fetched  output  32: delivered-instruction count (see Configuration).
- perf_squashed  output  32: discarded-response count (see Configuration).

## Operation
- State machine states: FETCH, WAIT, DRAIN.
- Reset values: state=FETCH, pc=RESET_PC, pend_pc=0, imem_req=0 while rst is high, if_valid=0, if_instr=0, if_pc=0, perf counters=0.
- FETCH:
  - imem_req=1 when the output register is free, i.e. if_valid=0, or if_valid=1 with dec_ready=1.
  - imem_addr=pc.
  - On imem_gnt: pend_pc<=pc, pc<=pc+4, go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: if_instr<=imem_rdata, if_pc<=pend_pc, if_valid<=1, go to FETCH.
- DRAIN:
  - imem_req=0.
  - On imem_rvalid: discard the data, increment perf_squashed, go to FETCH.
- Output register:
  - if_valid clears on dec_ready when no new response lands in the same cycle.
  - Holds its value while dec_ready=0.
- Redirect has priority over all other events:
  - pc<=redirect_target[ADDRESS_WIDTH-1:0] and if_valid<=0 in the same cycle.
  - In WAIT, go to DRAIN.
  - In FETCH with imem_gnt=1, the granted request is squashed: go to DRAIN.
  - In FETCH without a grant, stay in FETCH.
  - In DRAIN, stay in DRAIN and update pc.
  - Redirect in WAIT with imem_rvalid=1 in the same cycle: the response is discarded and the next state is FETCH.
- Arithmetic: pc+4 is modulo 2^ADDRESS_WIDTH. It wraps silently, e.g. 28+4=0 for ADDRESS_WIDTH=5.

## Timing
- imem_req/imem_addr are combinational from state, pc, if_valid and dec_ready. imem_gnt may arrive in the same cycle as the request.
- Minimum latency: request in cycle N, rvalid in N+1, if_valid in N+2.
- Back-to-back throughput: one instruction per two cycles (single outstanding request).
- Redirect in cycle N: the request to the new target can issue in N+1, unless the FSM is in DRAIN.
- imem_req must stay high with a stable imem_addr until imem_gnt, except when a redirect occurs.
- Reset asserted mid-operation: all state returns to reset values asynchronously. A later stale imem_rvalid in FETCH is ignored.

## Configuration
- FETCH_CTRL_PERF_EN defined:
  - perf_fetched increments on each cycle with if_valid && dec_ready.
  - perf_squashed increments on each discarded response.
  - Both counters are 32-bit and wrap.
- FETCH_CTRL_PERF_EN undefined: counters are not built; both ports are tied to 0.

## Test plan
- Reset release, RESET_PC=0, imem_gnt=1, 1-cycle memory, dec_ready=1 -> imem_addr sequence 0,4,8,12; if_pc matches, one instruction every 2 cycles.
- dec_ready=0 for 5 cycles holding instruction 0x00500093 at pc 4 -> if_valid/if_instr stable; imem_req=0 until dec_ready=1.
- Redirect to 0x10 while in WAIT for pc 8 -> the next rvalid is dropped, perf_squashed=1, next imem_addr=16, if_pc=16.
- Redirect to 0x0C in the same cycle as imem_gnt -> FSM enters DRAIN; after rvalid, imem_addr=12.
- pc=28, ADDRESS_WIDTH=5 -> next fetch address is 0.
- rst asserted while in WAIT, then rvalid one cycle after release -> if_valid stays 0, imem_addr=RESET_PC.
